// File: rtl/rings_pkg.sv
// Shared definitions for the concentric-rings drawing controller and its datapath:
// state encoding and the colour palette.
package rings_pkg;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_CLR_INIT  = 4'd1;
    localparam logic [3:0] S_CLR_PIX   = 4'd2;
    localparam logic [3:0] S_CLR_NEXTY = 4'd3;
    localparam logic [3:0] S_RING_INIT = 4'd4;
    localparam logic [3:0] S_OCT_START = 4'd5;
    localparam logic [3:0] S_OCT_LOAD  = 4'd6;
    localparam logic [3:0] S_OCT_WRITE = 4'd7;
    localparam logic [3:0] S_STEP      = 4'd8;
    localparam logic [3:0] S_CHECK     = 4'd9;
    localparam logic [3:0] S_RING_NEXT = 4'd10;
    localparam logic [3:0] S_RING_CHK  = 4'd11;
    localparam logic [3:0] S_DONE      = 4'd12;

    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] BLUE   = 3'b001;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] WHITE  = 3'b111;

    function automatic logic is_busy(input logic [3:0] st);
        return (st != S_IDLE) && (st != S_DONE);
    endfunction

endpackage

// File: rtl/rings_ctrl.sv
// Control FSM for clearing a 160x120 frame and drawing five midpoint circles.
// State register plus combinational next-state and output decode.
module rings_ctrl
    import rings_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start,
    input  logic       x_done,
    input  logic       y_done,
    input  logic       c_done,
    input  logic       crit_pos,
    input  logic       loop_done,
    input  logic       rings_done,
    input  logic [2:0] ring_col,
    output logic       blank,
    output logic       x_start,
    output logic       y_start,
    output logic       x_enable,
    output logic       y_enable,
    output logic       counter_start,
    output logic       counter_enable,
    output logic       x_off_enable,
    output logic       y_off_enable,
    output logic       off_clr,
    output logic       crit_enable,
    output logic       crit_sel,
    output logic       ring_en,
    output logic       ring_start,
    output logic       plot,
    output logic [2:0] colour,
    output logic       busy,
    output logic       done
);

    logic [3:0] state_q;
    logic [3:0] state_d;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        blank          = 1'b0;
        x_start        = 1'b0;
        y_start        = 1'b0;
        x_enable       = 1'b0;
        y_enable       = 1'b0;
        counter_start  = 1'b0;
        counter_enable = 1'b0;
        x_off_enable   = 1'b0;
        y_off_enable   = 1'b0;
        off_clr        = 1'b0;
        crit_enable    = 1'b0;
        crit_sel       = 1'b0;
        ring_en        = 1'b0;
        ring_start     = 1'b0;
        plot           = 1'b0;
        done           = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLR_INIT;
            end
            S_CLR_INIT: begin
                blank    = 1'b1;
                x_start  = 1'b1;
                y_start  = 1'b1;
                x_enable = 1'b1;
                y_enable = 1'b1;
                state_d  = S_CLR_PIX;
            end
            S_CLR_PIX: begin
                blank = 1'b1;
                // End-of-frame wins over end-of-row so the row after the last is never painted.
                if (y_done) begin
                    state_d = S_RING_INIT;
                end else if (x_done) begin
                    state_d = S_CLR_NEXTY;
                end else begin
                    plot     = 1'b1;
                    x_enable = 1'b1;
                end
            end
            S_CLR_NEXTY: begin
                blank    = 1'b1;
                x_start  = 1'b1;
                x_enable = 1'b1;
                y_enable = 1'b1;
                state_d  = S_CLR_PIX;
            end
            S_RING_INIT: begin
                ring_start   = 1'b1;
                ring_en      = 1'b1;
                crit_enable  = 1'b1;
                x_off_enable = 1'b1;
                off_clr      = 1'b1;
                state_d      = S_OCT_START;
            end
            S_OCT_START: begin
                counter_start = 1'b1;
                state_d       = S_OCT_LOAD;
            end
            S_OCT_LOAD: begin
                // Coordinates are latched here and plotted next cycle, keeping plot off the enables.
                if (c_done) begin
                    state_d = S_STEP;
                end else begin
                    x_enable = 1'b1;
                    y_enable = 1'b1;
                    state_d  = S_OCT_WRITE;
                end
            end
            S_OCT_WRITE: begin
                plot           = 1'b1;
                counter_enable = 1'b1;
                state_d        = S_OCT_LOAD;
            end
            S_STEP: begin
                y_off_enable = 1'b1;
                crit_enable  = 1'b1;
                crit_sel     = crit_pos;
                x_off_enable = crit_pos;
                state_d      = S_CHECK;
            end
            S_CHECK: begin
                state_d = loop_done ? S_RING_NEXT : S_OCT_START;
            end
            S_RING_NEXT: begin
                ring_en      = 1'b1;
                crit_enable  = 1'b1;
                x_off_enable = 1'b1;
                off_clr      = 1'b1;
                state_d      = S_RING_CHK;
            end
            S_RING_CHK: begin
                state_d = rings_done ? S_DONE : S_OCT_START;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_d = S_CLR_INIT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Gating on resetn keeps colour black while reset is held, even though IDLE is not blanking.
    assign colour = (blank || !resetn) ? BLACK : ring_col;
    assign busy   = is_busy(state_q);

endmodule

// File: tb/tb_rings_ctrl.sv
// Directed bench for rings_ctrl with a small behavioural datapath (frame counters,
// octant counter, radius-24 midpoint circle, ring counter) closing the loop.
module tb_rings_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic       start    = 1'b0;
    logic       x_done, y_done, c_done, crit_pos, loop_done, rings_done;
    logic [2:0] ring_col;
    logic       blank, x_start, y_start, x_enable, y_enable, counter_start, counter_enable;
    logic       x_off_enable, y_off_enable, off_clr, crit_enable, crit_sel, ring_en, ring_start;
    logic       plot, busy, done;
    logic [2:0] colour;

    rings_ctrl dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start),
        .x_done(x_done), .y_done(y_done), .c_done(c_done), .crit_pos(crit_pos),
        .loop_done(loop_done), .rings_done(rings_done), .ring_col(ring_col),
        .blank(blank), .x_start(x_start), .y_start(y_start), .x_enable(x_enable),
        .y_enable(y_enable), .counter_start(counter_start), .counter_enable(counter_enable),
        .x_off_enable(x_off_enable), .y_off_enable(y_off_enable), .off_clr(off_clr),
        .crit_enable(crit_enable), .crit_sel(crit_sel), .ring_en(ring_en),
        .ring_start(ring_start), .plot(plot), .colour(colour), .busy(busy), .done(done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    logic [19:0] outs;
    assign outs = {blank, x_start, y_start, x_enable, y_enable, counter_start, counter_enable,
                   x_off_enable, y_off_enable, off_clr, crit_enable, crit_sel, ring_en,
                   ring_start, plot, busy, done, colour};

    // Behavioural datapath
    int x = 0, y = 0, c = 0, r = 0, ox = 0, oy = 0, crit = 0;
    logic crit_ovr = 1'b0, crit_ovr_val = 1'b0;
    assign x_done     = (x == 160);
    assign y_done     = (y == 120);
    assign c_done     = (c > 7);
    assign crit_pos   = crit_ovr ? crit_ovr_val : (crit > 0);
    assign loop_done  = (oy > ox);
    assign rings_done = (r > 4);
    always_comb begin
        case (r)
            0:       ring_col = 3'b001;
            1:       ring_col = 3'b010;
            2:       ring_col = 3'b100;
            3:       ring_col = 3'b110;
            default: ring_col = 3'b111;
        endcase
    end

    always @(posedge CLOCK_50) begin
        if (x_start) x <= 0; else if (x_enable) x <= x + 1;
        if (y_start) y <= 0; else if (y_enable) y <= y + 1;
        if (counter_start) c <= 0; else if (counter_enable) c <= c + 1;
        if (ring_start) r <= 0; else if (ring_en) r <= r + 1;
        if (off_clr) begin
            oy <= 0; ox <= 24; crit <= 1 - 24;
        end else if (y_off_enable) begin
            oy <= oy + 1;
            if (crit_pos) begin
                ox   <= ox - 1;
                crit <= crit + 2 * ((oy + 1) - (ox - 1)) + 1;
            end else begin
                crit <= crit + 2 * (oy + 1) + 1;
            end
        end
    end

    // Event counters sampled on the active edge
    int cyc = 0, plot_cnt = 0, blank_plots = 0, col_bad = 0, overlap = 0, ring_cnt = 0;
    int iter_start = 0, iter_plots = 0, iter_cnt = 0, iter_bad = 0, clr_t0 = 0, clr_t1 = 0;
    always @(posedge CLOCK_50) begin
        cyc <= cyc + 1;
        if (plot) plot_cnt <= plot_cnt + 1;
        if (plot && blank) blank_plots <= blank_plots + 1;
        if (plot && ((blank && colour !== 3'b000) || (!blank && colour !== ring_col)))
            col_bad <= col_bad + 1;
        if (plot && !blank && (x_enable || y_enable)) overlap <= overlap + 1;
        if (ring_en) ring_cnt <= ring_cnt + 1;
        if (x_start && y_start) clr_t0 <= cyc;
        if (ring_start) clr_t1 <= cyc;
        if (counter_start) begin
            iter_start <= cyc;
            iter_plots <= 0;
        end else if (plot && !blank) begin
            iter_plots <= iter_plots + 1;
        end
        if (y_off_enable) begin
            iter_cnt <= iter_cnt + 1;
            if ((cyc - iter_start) != 18 || iter_plots != 8) iter_bad <= iter_bad + 1;
        end
    end

    int ncheck = 0, npass = 0;
    task automatic check(input string tag, input int obs, input int exp);
        ncheck++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    int snap_plot, snap_blank, snap_col, snap_ovl, snap_ring, snap_iter, snap_ibad;
    bit seen;

    initial begin
        // Reset held
        repeat (3) @(negedge CLOCK_50);
        check("reset_outs", int'(outs), 0);
        resetn = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        check("idle_busy", int'(busy), 0);
        check("idle_no_plot", plot_cnt, 0);

        // Start, then reset mid-clear
        start = 1'b1; @(negedge CLOCK_50); start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        repeat (5000) @(negedge CLOCK_50);
        check("midclear_blank", int'(blank), 1);
        resetn = 1'b0;
        #1;
        check("midclear_reset_outs", int'(outs), 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        snap_plot = plot_cnt;
        repeat (40) @(negedge CLOCK_50);
        check("post_reset_no_plot", plot_cnt - snap_plot, 0);
        check("post_reset_busy", int'(busy), 0);

        // Full run with spurious starts while busy
        snap_col = col_bad; snap_ovl = overlap; snap_ring = ring_cnt;
        snap_iter = iter_cnt; snap_ibad = iter_bad; snap_blank = blank_plots; snap_plot = plot_cnt;
        start = 1'b1; @(negedge CLOCK_50); start = 1'b0;
        check("busy_after_start2", int'(busy), 1);
        seen = 0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            start = (i == 100 || i == 10000);
            @(negedge CLOCK_50);
            seen = ring_start;
        end
        start = 1'b0;
        check("ring_init_reached", int'(seen), 1);
        @(negedge CLOCK_50);
        check("clear_cycles", clr_t1 - clr_t0, 19442);
        check("clear_plots", plot_cnt - snap_plot, 19200);
        check("clear_blank_plots", blank_plots - snap_blank, 19200);
        seen = 0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            start = (i == 50);
            @(negedge CLOCK_50);
            seen = done;
        end
        start = 1'b0;
        check("done_reached", int'(seen), 1);
        check("ring_en_pulses", ring_cnt - snap_ring, 6);
        check("iter_bad", iter_bad - snap_ibad, 0);
        check("iter_enough", int'((iter_cnt - snap_iter) >= 5), 1);
        check("colour_bad", col_bad - snap_col, 0);
        check("plot_enable_overlap", overlap - snap_ovl, 0);
        check("done_busy", int'(busy), 0);
        repeat (5) @(negedge CLOCK_50);
        check("done_held", int'(done), 1);

        // Redraw from DONE, then STEP decode with forced criterion
        start = 1'b1; @(negedge CLOCK_50); start = 1'b0;
        check("redraw_done_low", int'(done), 0);
        check("redraw_busy", int'(busy), 1);
        check("redraw_clr_init", int'(x_start && y_start), 1);
        seen = 0;
        for (int i = 0; i < 25000 && !seen; i++) begin
            @(negedge CLOCK_50);
            seen = y_off_enable;
        end
        check("step_reached", int'(seen), 1);
        crit_ovr = 1'b1; crit_ovr_val = 1'b1; #1;
        check("step_pos_crit_sel", int'(crit_sel), 1);
        check("step_pos_x_off", int'(x_off_enable), 1);
        check("step_pos_y_off", int'(y_off_enable), 1);
        crit_ovr_val = 1'b0; #1;
        check("step_neg_crit_sel", int'(crit_sel), 0);
        check("step_neg_x_off", int'(x_off_enable), 0);
        check("step_neg_y_off", int'(y_off_enable), 1);
        crit_ovr = 1'b0;

        // Reset mid-ring
        repeat (7) @(negedge CLOCK_50);
        resetn = 1'b0;
        #1;
        check("midring_reset_outs", int'(outs), 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        snap_plot = plot_cnt;
        repeat (30) @(negedge CLOCK_50);
        check("midring_no_plot", plot_cnt - snap_plot, 0);

        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end

endmodule

// File: doc/rings_ctrl.md
RINGS_CTRL -- requirements
Module: rings_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset, as ports: CLOCK_50 in 1 system clock; resetn in 1 async active-low reset.
REQ-002 Inputs SHALL be: start 1 (pulse, begin full drawing); x_done 1 (x==160); y_done 1 (y==120); c_done 1 (octant counter >7); crit_pos 1 (criterion >0); loop_done 1 (offset_y > offset_x); rings_done 1 (ring counter >4); ring_col 3 (current ring colour).
REQ-003 Outputs SHALL be, all 1 bit unless stated: blank; x_start; y_start; x_enable; y_enable; counter_start; counter_enable; x_off_enable; y_off_enable; off_clr (clears offset_y); crit_enable; crit_sel; ring_en; ring_start; plot; colour 3; busy; done.

Function
REQ-004 SHALL be a Moore FSM with states IDLE, CLR_INIT, CLR_PIX, CLR_NEXTY, RING_INIT, OCT_START, OCT_LOAD, OCT_WRITE, STEP, CHECK, RING_NEXT, RING_CHK, DONE; all outputs decoded from state plus listed inputs only; unlisted outputs are 0.
REQ-005 IDLE: start=1 -> CLR_INIT; else stay.
REQ-006 CLR_INIT: blank, x_start, y_start, x_enable, y_enable =1; -> CLR_PIX.
REQ-007 CLR_PIX: blank=1; if y_done -> RING_INIT, no plot; elif x_done -> CLR_NEXTY, no plot; else plot=1, x_enable=1, stay.
REQ-008 CLR_NEXTY: blank, x_start, x_enable, y_enable =1 (x<-0, y<-y+1); -> CLR_PIX.
REQ-009 RING_INIT: ring_start, ring_en, crit_enable, x_off_enable, off_clr =1; -> OCT_START.
REQ-010 OCT_START: counter_start=1; -> OCT_LOAD.
REQ-011 OCT_LOAD: if c_done -> STEP; else x_enable, y_enable =1 (blank=0) -> OCT_WRITE.
REQ-012 OCT_WRITE: plot=1, counter_enable=1; -> OCT_LOAD.
REQ-013 STEP: y_off_enable=1, crit_enable=1; crit_sel=crit_pos; x_off_enable=crit_pos; -> CHECK.
REQ-014 CHECK: loop_done -> RING_NEXT; else -> OCT_START.
REQ-015 RING_NEXT: ring_en, crit_enable, x_off_enable, off_clr =1; -> RING_CHK.
REQ-016 RING_CHK: rings_done -> DONE; else -> OCT_START.
REQ-017 DONE: done=1; start=1 -> CLR_INIT (redraw); else stay.
REQ-018 colour SHALL be 3'b000 while blank=1, else ring_col.
REQ-019 busy SHALL be 1 in every state except IDLE and DONE; start while busy SHALL be ignored.
REQ-020 Clear phase SHALL take exactly 19442 cycles from CLR_INIT entry to RING_INIT entry, with exactly 19200 plot pulses (one per pixel, 160x120).
REQ-021 Each circle iteration SHALL take exactly 20 cycles (OCT_START..CHECK) and emit exactly 8 plot pulses, plot never asserted in the same cycle as x_enable/y_enable.
REQ-022 Exactly 5 rings SHALL be drawn per start; done SHALL rise one cycle after the RING_CHK that sees rings_done.

Reset
REQ-023 resetn=0 SHALL immediately force IDLE, all outputs 0, colour 3'b000, regardless of state, including mid-clear or mid-ring.
REQ-024 After resetn release, the FSM SHALL remain in IDLE until a start pulse; no plot SHALL occur before it.

Structure
REQ-025 State encoding (4-bit enum) and colour constants (BLACK 000, BLUE 001, GREEN 010, RED 100, YELLOW 110, WHITE 111) SHALL live in a shared rings package used by controller and datapath.
REQ-026 The block SHALL be a single module, state register plus next-state/output decode, no sub-modules.

Verification
REQ-027 Reset, then start pulse -> busy=1 next cycle; 19200 plot pulses with blank=1, colour=000, before RING_INIT.
REQ-028 Datapath model with radius 24 -> every circle plot pulse has colour=ring_col, each iteration exactly 8 plots within 20 cycles.
REQ-029 Full run -> ring_en pulses: 1 in RING_INIT + 5 in RING_NEXT; done=1 held, busy=0 after 5th ring.
REQ-030 Force crit_pos=1 in STEP -> crit_sel=1, x_off_enable=1; crit_pos=0 -> both 0, y_off_enable=1 in both.
REQ-031 resetn=0 at cycle 5000 (mid-clear) -> all outputs 0 same cycle; after release, no plot until new start.
REQ-032 start pulses while busy -> ignored (no restart); start in DONE -> CLR_INIT next cycle, done=0.
